// File: rtl/alu_issue_stage.sv
// ID/EX issue register for the ALU: decodes opcode/funct into an ALU operation
// and operand pair, registered for EX with flush > stall > load priority.
module alu_issue_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        stall,
  input  logic        flush,
  output logic        ex_valid,
  output logic [2:0]  ALUOp,
  output logic [31:0] In1,
  output logic [31:0] In2,
  output logic        illegal,
  output logic [7:0]  illegal_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_ADD = 3'b001,
    OP_SUB = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_SLT = 3'b101
  } alu_op_e;

  state_e      state_q, state_d;
  alu_op_e     aluop_q, aluop_d;
  logic [31:0] in1_q, in1_d;
  logic [31:0] in2_q, in2_d;
  logic        illegal_q, illegal_d;
  logic [7:0]  cnt_q, cnt_d;

  alu_op_e     dec_op;
  logic [31:0] dec_in1;
  logic [31:0] dec_in2;
  logic        dec_ill;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;

  assign imm_sext = {{16{imm[15]}}, imm};
  assign imm_zext = {16'h0000, imm};

  always_comb begin
    dec_op  = OP_NOP;
    dec_in1 = '0;
    dec_in2 = '0;
    dec_ill = 1'b0;
    unique case (opcode)
      6'b000000: begin
        unique case (funct)
          6'b100000: begin dec_op = OP_ADD; dec_in1 = rs_data; dec_in2 = rt_data; end
          6'b100010: begin dec_op = OP_SUB; dec_in1 = rs_data; dec_in2 = rt_data; end
          6'b100100: begin dec_op = OP_AND; dec_in1 = rs_data; dec_in2 = rt_data; end
          6'b100101: begin dec_op = OP_OR;  dec_in1 = rs_data; dec_in2 = rt_data; end
          6'b101010: begin dec_op = OP_SLT; dec_in1 = rs_data; dec_in2 = rt_data; end
          6'b000000: ;
          default:   dec_ill = 1'b1;
        endcase
      end
      6'b001000, 6'b100011, 6'b101011: begin
        dec_op = OP_ADD; dec_in1 = rs_data; dec_in2 = imm_sext;
      end
      6'b001010: begin dec_op = OP_SLT; dec_in1 = rs_data; dec_in2 = imm_sext; end
      6'b001100: begin dec_op = OP_AND; dec_in1 = rs_data; dec_in2 = imm_zext; end
      6'b001101: begin dec_op = OP_OR;  dec_in1 = rs_data; dec_in2 = imm_zext; end
      6'b000100: begin dec_op = OP_SUB; dec_in1 = rs_data; dec_in2 = rt_data; end
      6'b000010: ;
      default:   dec_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    aluop_d   = aluop_q;
    in1_d     = in1_q;
    in2_d     = in2_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    if (flush || (!stall && !in_valid)) begin
      state_d   = EMPTY;
      aluop_d   = OP_NOP;
      in1_d     = '0;
      in2_d     = '0;
      illegal_d = 1'b0;
    end else if (!stall) begin
      state_d   = FULL;
      aluop_d   = dec_op;
      in1_d     = dec_in1;
      in2_d     = dec_in2;
      illegal_d = dec_ill;
      if (dec_ill && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= EMPTY;
      aluop_q   <= OP_NOP;
      in1_q     <= '0;
      in2_q     <= '0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      aluop_q   <= aluop_d;
      in1_q     <= in1_d;
      in2_q     <= in2_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign ex_valid    = (state_q == FULL);
  assign ALUOp       = aluop_q;
  assign In1         = in1_q;
  assign In2         = in2_q;
  assign illegal     = illegal_q;
  assign illegal_cnt = cnt_q;

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Purpose: ID/EX-side producer for the ALU. It decodes each instruction into the 3-bit ALU operation and the two 32-bit operands, and registers them for the EX stage, with stall and flush handling.

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 One clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 in_valid  input  1  the ID-stage instruction fields are valid this cycle.
REQ-006 opcode  input  6  instruction bits [31:26].
REQ-007 funct  input  6  instruction bits [5:0].
REQ-008 imm  input  16  instruction bits [15:0].
REQ-009 rs_data  input  32  register-file read port A.
REQ-010 rt_data  input  32  register-file read port B.
REQ-011 stall  input  1  hold the EX register.
REQ-012 flush  input  1  replace the EX register contents with a bubble.
REQ-013 ex_valid  output  1  the EX-stage entry is valid.
REQ-014 ALUOp  output  3  ALU operation: 000 nop, 001 add, 010 sub, 011 and, 100 or, 101 slt.
REQ-015 In1  output  32  ALU operand 1.
REQ-016 In2  output  32  ALU operand 2.
REQ-017 illegal  output  1  the EX-stage entry was an undecodable instruction.
REQ-018 illegal_cnt  output  8  saturating count of illegal instructions accepted.

Function
REQ-019 R-type (opcode 000000), by funct:
- 100000 -> 001 (add)
- 100010 -> 010 (sub)
- 100100 -> 011 (and)
- 100101 -> 100 (or)
- 101010 -> 101 (slt)
- In1=rs_data, In2=rt_data.
REQ-020 R-type with funct 000000 -> ALUOp 000, In1=In2=0, not illegal.
REQ-021 addi 001000, slti 001010, lw 100011, sw 101011 -> ALUOp 001/101/001/001; In1=rs_data; In2 = sign-extended imm.
REQ-022 andi 001100, ori 001101 -> ALUOp 011/100; In1=rs_data; In2 = zero-extended imm.
REQ-023 beq 000100 -> ALUOp 010, In1=rs_data, In2=rt_data.
REQ-024 j 000010 -> ALUOp 000, In1=In2=0, not illegal.
REQ-025 Any other opcode, or any other R-type funct -> ALUOp 000, In1=In2=0, illegal=1.
REQ-026 Latency: exactly one cycle.
- Fields decoded in cycle N appear on the outputs after rising edge N+1.
- The outputs are registers only; there is no combinational path from inputs to outputs.
REQ-027 Per-edge priority, highest first:
- flush: load a bubble (ex_valid=0, ALUOp=000, In1=In2=0, illegal=0).
- stall: hold every output register unchanged.
- in_valid=1: load the decoded entry with ex_valid=1.
- in_valid=0: load a bubble.
REQ-028 flush and stall asserted together -> bubble; flush wins.
REQ-029 illegal_cnt counting:
- Increments by 1 only on an edge that loads an entry with in_valid=1 and illegal=1.
- Saturates at 255, with no wrap.
- Held while stall or flush is asserted.
REQ-030 While in_valid=0, the decode inputs are ignored and do not affect the outputs or illegal_cnt.
REQ-031 The block is a two-state entry machine, EMPTY (ex_valid=0) and FULL (ex_valid=1):
- EMPTY->FULL on a load with in_valid.
- FULL->EMPTY on flush, or on a load with in_valid=0.
- Stall holds the current state.

Reset
REQ-032 While rst=1, regardless of clk:
- ex_valid=0, ALUOp=000, In1=0, In2=0, illegal=0, illegal_cnt=0.
REQ-033 Reset asserted mid-operation discards the held entry immediately.
REQ-034 First load after rst deasserts: the first rising edge with rst=0 follows REQ-027.

Verification
REQ-035 The bench shall cover these directed scenarios:
- R-add: opcode 000000, funct 100000, rs=5, rt=7, in_valid=1 -> next edge: ex_valid=1, ALUOp=001, In1=5, In2=7.
- Immediate sign/zero extension: addi with imm=FFFF -> In2=FFFFFFFF, ALUOp=001. Then ori with imm=FFFF -> In2=0000FFFF, ALUOp=100.
- Stall then flush: load slti (ALUOp=101). Assert stall for 3 cycles -> outputs unchanged. Then assert stall=1 and flush=1 together -> ex_valid=0, ALUOp=000, In1=In2=0.
- Illegal instruction: opcode 111111 with in_valid=1 -> illegal=1, ALUOp=000, illegal_cnt 0->1. Then 300 consecutive illegal loads -> illegal_cnt=255.
- Async reset: assert rst between clock edges while ex_valid=1 and illegal_cnt=4 -> all outputs 0 before the next edge.
- Bubble load: in_valid=0 with opcode=lw -> ex_valid=0, ALUOp=000, illegal_cnt unchanged.
